// File: rtl/search_scheduler.sv
// Round-robin scheduler sharing one pattern-search engine among NREQ requesters.
// Define SEARCH_TIMEOUT_EN to add an engine watchdog and the rsp_timeout output.
module search_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 8
`ifdef SEARCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_p,
  input  logic [NREQ*AW-1:0] req_pl,
  input  logic [NREQ*AW-1:0] req_b,
  input  logic [NREQ*AW-1:0] req_bl,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [AW-1:0]     rsp_found,
  output logic              rsp_hit,
`ifdef SEARCH_TIMEOUT_EN
  output logic              rsp_timeout,
`endif
  output logic              busy,
  output logic [AW-1:0]     eng_p,
  output logic [AW-1:0]     eng_pl,
  output logic [AW-1:0]     eng_b,
  output logic [AW-1:0]     eng_bl,
  output logic              eng_activate,
  input  logic              eng_done,
  input  logic [AW-1:0]     eng_found
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESPOND} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   rr, rr_d, gidx, gidx_d;
  logic            done_q, done_rise;
  logic [NREQ-1:0] grant_d, rsp_valid_d;
  logic [AW-1:0]   rsp_found_d, eng_p_d, eng_pl_d, eng_b_d, eng_bl_d;
  logic            rsp_hit_d, busy_d, eng_activate_d;

  logic            pick_ok;
  logic [IW-1:0]   pick_idx, cand;
  logic [AW-1:0]   sel_p, sel_pl, sel_b, sel_bl;

`ifdef SEARCH_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]   wait_cnt, wait_cnt_d;
  logic            tmo, tmo_d, rsp_timeout_d;
`endif

  assign done_rise = eng_done & ~done_q;

  // First requesting index after the last served one, wrapping modulo NREQ.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(rr) + k) % NREQ);
      if (!pick_ok && req[cand]) begin
        pick_ok  = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Operand mux for the candidate requester.
  always_comb begin
    sel_p  = '0;
    sel_pl = '0;
    sel_b  = '0;
    sel_bl = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_p  = req_p[i*AW +: AW];
        sel_pl = req_pl[i*AW +: AW];
        sel_b  = req_b[i*AW +: AW];
        sel_bl = req_bl[i*AW +: AW];
      end
    end
  end

  always_comb begin
    state_d        = state;
    rr_d           = rr;
    gidx_d         = gidx;
    grant_d        = grant;
    rsp_valid_d    = '0;
    rsp_found_d    = rsp_found;
    rsp_hit_d      = rsp_hit;
    busy_d         = busy;
    eng_p_d        = eng_p;
    eng_pl_d       = eng_pl;
    eng_b_d        = eng_b;
    eng_bl_d       = eng_bl;
    eng_activate_d = 1'b0;
`ifdef SEARCH_TIMEOUT_EN
    wait_cnt_d     = wait_cnt;
    tmo_d          = tmo;
    rsp_timeout_d  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (pick_ok) begin
          gidx_d   = pick_idx;
          grant_d  = NREQ'(1) << pick_idx;
          busy_d   = 1'b1;
          eng_p_d  = sel_p;
          eng_pl_d = sel_pl;
          eng_b_d  = sel_b;
          eng_bl_d = sel_bl;
          // Degenerate operands are answered directly; the engine stays idle.
          if (sel_pl == '0 || sel_bl == '0 || sel_pl > sel_bl) begin
            rsp_found_d = '1;
            rsp_hit_d   = 1'b0;
            state_d     = S_RESPOND;
          end else begin
            eng_activate_d = 1'b1;
            state_d        = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
`ifdef SEARCH_TIMEOUT_EN
        wait_cnt_d = '0;
        tmo_d      = 1'b0;
`endif
      end
      S_WAIT: begin
        if (done_rise) begin
          rsp_found_d = eng_found;
          rsp_hit_d   = (eng_found != '1);
          state_d     = S_RESPOND;
        end
`ifdef SEARCH_TIMEOUT_EN
        else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          rsp_found_d = '1;
          rsp_hit_d   = 1'b0;
          tmo_d       = 1'b1;
          state_d     = S_RESPOND;
        end else begin
          wait_cnt_d = wait_cnt + CW'(1);
        end
`endif
      end
      S_RESPOND: begin
        rsp_valid_d = NREQ'(1) << gidx;
        grant_d     = '0;
        rr_d        = gidx;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
`ifdef SEARCH_TIMEOUT_EN
        rsp_timeout_d = tmo;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      rr           <= IW'(NREQ - 1);
      gidx         <= '0;
      done_q       <= 1'b0;
      grant        <= '0;
      rsp_valid    <= '0;
      rsp_found    <= '0;
      rsp_hit      <= 1'b0;
      busy         <= 1'b0;
      eng_p        <= '0;
      eng_pl       <= '0;
      eng_b        <= '0;
      eng_bl       <= '0;
      eng_activate <= 1'b0;
`ifdef SEARCH_TIMEOUT_EN
      wait_cnt     <= '0;
      tmo          <= 1'b0;
      rsp_timeout  <= 1'b0;
`endif
    end else begin
      state        <= state_d;
      rr           <= rr_d;
      gidx         <= gidx_d;
      done_q       <= eng_done;
      grant        <= grant_d;
      rsp_valid    <= rsp_valid_d;
      rsp_found    <= rsp_found_d;
      rsp_hit      <= rsp_hit_d;
      busy         <= busy_d;
      eng_p        <= eng_p_d;
      eng_pl       <= eng_pl_d;
      eng_b        <= eng_b_d;
      eng_bl       <= eng_bl_d;
      eng_activate <= eng_activate_d;
`ifdef SEARCH_TIMEOUT_EN
      wait_cnt     <= wait_cnt_d;
      tmo          <= tmo_d;
      rsp_timeout  <= rsp_timeout_d;
`endif
    end
  end

endmodule
